// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, instruction field positions and FSM state encoding for the ALU sequencer.
package alu_seq_pkg;
   localparam logic [2:0] OP_ADD    = 3'h0;
   localparam logic [2:0] OP_COMPL  = 3'h1;
   localparam logic [2:0] OP_SHR    = 3'h2;
   localparam logic [2:0] OP_SHL    = 3'h3;
   localparam logic [2:0] OP_COMPC  = 3'h4;
   localparam logic [2:0] OP_COMPN  = 3'h5;
   localparam logic [2:0] OP_CONST1 = 3'h6;
   localparam logic [2:0] OP_LOAD   = 3'h7;
   localparam int HALT_BIT = 7;
   localparam int OP_MSB   = 6;
   localparam int OP_LSB   = 4;
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_DONE   = 3'd5,
      S_PAUSE  = 3'd6
   } state_t;
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: host, program ROM and ALU signals of the sequencer.
// SINGLE_STEP_EN adds the host step input.
interface alu_seq_ctrl_if #(parameter int ADDR_W = 4, parameter int DATA_W = 4);
   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_en;
   logic [7:0]        rom_data;
   logic [2:0]        alu_opcode;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;
   logic [DATA_W-1:0] acc;
   logic              flag_z;
   logic              flag_c;
`ifdef SINGLE_STEP_EN
   logic              step;
`endif
   modport master (
`ifdef SINGLE_STEP_EN
      input step,
`endif
      input start, rom_data, alu_result, alu_carry,
      output busy, done, rom_addr, rom_en, alu_opcode, alu_a, alu_b, acc, flag_z, flag_c
   );
   modport slave (
`ifdef SINGLE_STEP_EN
      output step,
`endif
      output start, rom_data, alu_result, alu_carry,
      input busy, done, rom_addr, rom_en, alu_opcode, alu_a, alu_b, acc, flag_z, flag_c
   );
endinterface

// File: rtl/prog_counter.sv
// prog_counter: program counter with sync clear, increment enable and last-address flag.
module prog_counter #(parameter int ADDR_W = 4) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   output logic [ADDR_W-1:0] cnt,
   output logic              last
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
   assign last = &cnt;
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multicycle fetch/decode/exec/writeback sequencer driving the 4-bit ALU.
// SINGLE_STEP_EN holds the sequencer in PAUSE between instructions until a step pulse.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input logic           clk,
   input logic           rst_n,
   alu_seq_ctrl_if.master bus
);
   state_t state, state_nx;
   logic [7:0]        ir;
   logic [DATA_W-1:0] acc_q, res_q;
   logic              car_q, z_q, c_q, last;
   logic [ADDR_W-1:0] pc;
   logic [2:0]        op;
   assign op = ir[OP_MSB:OP_LSB];
   prog_counter #(.ADDR_W(ADDR_W)) u_pc (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (state == S_IDLE && bus.start),
      .inc  (state == S_WB),
      .cnt  (pc),
      .last (last)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= state_nx;
   // ALU output is captured at the end of EXEC because the opcode returns to 0 in WB
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ir    <= '0;
         res_q <= '0;
         car_q <= 1'b0;
         acc_q <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
      end else begin
         if (state == S_DECODE) ir <= bus.rom_data;
         if (state == S_EXEC) begin
            res_q <= bus.alu_result;
            car_q <= bus.alu_carry;
         end
         if (state == S_WB) begin
            acc_q <= res_q;
            z_q   <= res_q == '0;
            c_q   <= op == OP_ADD && car_q;
         end
      end
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   state_nx = bus.start ? S_FETCH : S_IDLE;
         S_FETCH:  state_nx = S_DECODE;
         S_DECODE: state_nx = S_EXEC;
         S_EXEC:   state_nx = S_WB;
`ifdef SINGLE_STEP_EN
         S_WB:     state_nx = (ir[HALT_BIT] || last) ? S_DONE : S_PAUSE;
         S_PAUSE:  state_nx = bus.step ? S_FETCH : S_PAUSE;
`else
         S_WB:     state_nx = (ir[HALT_BIT] || last) ? S_DONE : S_FETCH;
`endif
         default:  state_nx = S_IDLE;
      endcase
   end
   assign bus.busy       = state != S_IDLE;
   assign bus.done       = state == S_DONE;
   assign bus.rom_en     = state == S_FETCH;
   assign bus.rom_addr   = pc;
   assign bus.alu_opcode = state == S_EXEC ? op : 3'h0;
   assign bus.alu_b      = state == S_EXEC ? DATA_W'(ir[OP_LSB-1:0]) : '0;
   assign bus.alu_a      = acc_q;
   assign bus.acc        = acc_q;
   assign bus.flag_z     = z_q;
   assign bus.flag_c     = c_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized program runs against a program-level reference model.
module tb_alu_seq_ctrl;
   localparam int AW = 4;
   localparam int DW = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   int last_cyc;
   logic [3:0] m_acc = '0;
   logic m_z = 1'b0;
   logic m_c = 1'b0;
   logic [7:0] rom [16];
   logic [7:0] rom_q;
   always #5 clk = ~clk;
   alu_seq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   alu_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rom_q <= '0;
      else if (bus.rom_en) rom_q <= rom[bus.rom_addr];
   assign bus.rom_data = rom_q;
   function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      logic [3:0] r;
      s = {1'b0, a} + {1'b0, b};
      case (op)
         3'h0: r = s[3:0];
         3'h1: r = ~a;
         3'h2: r = a >> 1;
         3'h3: r = a << 1;
         3'h4: r = -a;
         3'h5: r = ~b;
         3'h6: r = 4'h1;
         default: r = b;
      endcase
      return {s[4], r};
   endfunction
   assign {bus.alu_carry, bus.alu_result} = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);
   task automatic rand_rom(input bit no_halt);
      for (int i = 0; i < 16; i++) begin
         rom[i] = 8'($urandom);
         if (no_halt || $urandom_range(3) != 0) rom[i][7] = 1'b0;
      end
   endtask
   task automatic run_prog(input string name, input bit glitch);
      logic [3:0] tr[$];
      logic [4:0] r;
      logic [3:0] a;
      int pc, cnt, nf, epc;
      bit dn;
      a = m_acc;
      pc = 0;
      nf = 0;
      dn = 0;
      forever begin
         r = alu_f(rom[pc][6:4], a, rom[pc][3:0]);
         a = r[3:0];
         m_z = a == 4'h0;
         m_c = rom[pc][6:4] == 3'h0 ? r[4] : 1'b0;
         tr.push_back(a);
         if (rom[pc][7] || pc == 15) break;
         pc++;
      end
      m_acc = a;
      epc = (pc + 1) % 16;
      @(negedge clk);
      bus.start = 1'b1;
      cnt = 1;
      while (!dn && cnt < 200) begin
         @(negedge clk);
         cnt++;
         bus.start = glitch && (cnt % 4 == 1);
         if (bus.rom_en) begin
            total++;
            if (bus.alu_opcode !== 3'h0 || bus.alu_b !== 4'h0) begin
               bad++;
               $display("FAIL %s alu_idle: op=%0h b=%0h required 0 0", name, bus.alu_opcode, bus.alu_b);
            end
            if (nf > 0 && nf <= tr.size()) begin
               total++;
               if (bus.acc !== tr[nf-1]) begin
                  bad++;
                  $display("FAIL %s acc_step%0d: got %0h required %0h", name, nf - 1, bus.acc, tr[nf-1]);
               end
            end
            nf++;
         end
         if (bus.done) begin
            dn = 1;
            total++;
            if (nf == 0 || nf > tr.size() || bus.acc !== tr[nf-1]) begin
               bad++;
               $display("FAIL %s acc_final: got %0h required %0h after %0d fetches", name, bus.acc, a, nf);
            end
         end
      end
      last_cyc = cnt;
      total++;
      if (!dn) begin
         bad++;
         $display("FAIL %s timeout: no done within %0d cycles", name, cnt);
      end
      total++;
      if (cnt !== 4 * tr.size() + 2 || nf !== tr.size()) begin
         bad++;
         $display("FAIL %s latency: got %0d cycles %0d fetches required %0d cycles %0d fetches",
                  name, cnt, nf, 4 * tr.size() + 2, tr.size());
      end
      total++;
      if (bus.flag_z !== m_z || bus.flag_c !== m_c || bus.rom_addr !== 4'(epc)) begin
         bad++;
         $display("FAIL %s flags_pc: got z=%0b c=%0b pc=%0d required z=%0b c=%0b pc=%0d",
                  name, bus.flag_z, bus.flag_c, bus.rom_addr, m_z, m_c, epc);
      end
      bus.start = glitch;
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.rom_addr !== 4'(epc)) begin
         bad++;
         $display("FAIL %s after_done: got done=%0b busy=%0b pc=%0d required 0 0 %0d",
                  name, bus.done, bus.busy, bus.rom_addr, epc);
      end
   endtask
   task automatic test_reset();
      bus.start = 1'b0;
`ifdef SINGLE_STEP_EN
      bus.step = 1'b0;
`endif
      rst_n = 1'b0;
      #2;
      total++;
      if ({bus.busy, bus.done, bus.rom_en, bus.rom_addr, bus.alu_opcode, bus.alu_a, bus.alu_b} !== '0) begin
         bad++;
         $display("FAIL reset_ctrl: busy=%0b done=%0b en=%0b addr=%0h op=%0h a=%0h b=%0h required all 0",
                  bus.busy, bus.done, bus.rom_en, bus.rom_addr, bus.alu_opcode, bus.alu_a, bus.alu_b);
      end
      total++;
      if ({bus.acc, bus.flag_z, bus.flag_c} !== '0) begin
         bad++;
         $display("FAIL reset_acc: acc=%0h z=%0b c=%0b required 0 0 0", bus.acc, bus.flag_z, bus.flag_c);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_load_add();
      rand_rom(0);
      rom[0] = 8'h07;
      rom[1] = 8'h03;
      rom[2] = 8'h80;
      run_prog("load_add", 0);
      total++;
      if (bus.acc !== 4'd10 || bus.flag_z !== 1'b0 || bus.flag_c !== 1'b0 || last_cyc !== 14) begin
         bad++;
         $display("FAIL load_add_const: acc=%0d z=%0b c=%0b cyc=%0d required 10 0 0 14",
                  bus.acc, bus.flag_z, bus.flag_c, last_cyc);
      end
   endtask
   task automatic test_exec_reset();
      rand_rom(0);
      rom[0] = 8'h25;
      @(negedge clk);
      bus.start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      total++;
      if (bus.alu_opcode !== 3'h2 || bus.alu_b !== 4'h5 || bus.alu_a !== bus.acc) begin
         bad++;
         $display("FAIL exec_drive: op=%0h b=%0h a=%0h required 2 5 %0h", bus.alu_opcode, bus.alu_b, bus.alu_a, bus.acc);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.acc !== 4'h0 || bus.rom_addr !== 4'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL exec_reset: acc=%0h pc=%0h busy=%0b done=%0b required 0 0 0 0",
                  bus.acc, bus.rom_addr, bus.busy, bus.done);
      end
      repeat (3) begin
         @(negedge clk);
         total++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL exec_reset_hold: done=%0b busy=%0b required 0 0", bus.done, bus.busy);
         end
      end
      rst_n = 1'b1;
      m_acc = '0;
      m_z = 1'b0;
      m_c = 1'b0;
      rand_rom(0);
      run_prog("after_reset", 0);
   endtask
   task automatic test_overflow();
      rand_rom(0);
      rom[0] = 8'h7F;
      rom[1] = 8'h81;
      run_prog("overflow", 0);
      total++;
      if (bus.acc !== 4'h0 || bus.flag_z !== 1'b1 || bus.flag_c !== 1'b1) begin
         bad++;
         $display("FAIL overflow_const: acc=%0h z=%0b c=%0b required 0 1 1", bus.acc, bus.flag_z, bus.flag_c);
      end
   endtask
   task automatic test_wrap();
      rand_rom(1);
      run_prog("wrap", 0);
      total++;
      if (last_cyc !== 66 || bus.rom_addr !== 4'h0) begin
         bad++;
         $display("FAIL wrap_const: cyc=%0d pc=%0d required 66 0", last_cyc, bus.rom_addr);
      end
   endtask
   task automatic test_back_to_back();
      for (int k = 0; k < 6; k++) begin
         rand_rom(0);
         run_prog($sformatf("b2b%0d", k), 1);
      end
   endtask
`ifdef SINGLE_STEP_EN
   task automatic test_step();
      int cnt;
      rom[0] = 8'h73;
      rom[1] = 8'h04;
      rom[2] = 8'h81;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (12) @(negedge clk);
      total++;
      if (bus.busy !== 1'b1 || bus.acc !== 4'd3 || bus.rom_en !== 1'b0 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL step_pause: busy=%0b acc=%0d en=%0b done=%0b required 1 3 0 0", bus.busy, bus.acc, bus.rom_en, bus.done);
      end
      bus.step = 1'b1;
      @(negedge clk);
      bus.step = 1'b0;
      repeat (6) @(negedge clk);
      total++;
      if (bus.busy !== 1'b1 || bus.acc !== 4'd7 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL step_one: busy=%0b acc=%0d done=%0b required 1 7 0", bus.busy, bus.acc, bus.done);
      end
      bus.step = 1'b1;
      @(negedge clk);
      bus.step = 1'b0;
      cnt = 0;
      while (bus.done !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      total++;
      if (bus.done !== 1'b1 || bus.acc !== 4'd8) begin
         bad++;
         $display("FAIL step_done: done=%0b acc=%0d required 1 8", bus.done, bus.acc);
      end
      @(negedge clk);
   endtask
`endif
   initial begin
      test_reset();
`ifdef SINGLE_STEP_EN
      test_step();
`else
      test_load_add();
      test_exec_reset();
      test_overflow();
      test_wrap();
      test_back_to_back();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
